adc_spi_responder: RTL and testbench



---
 rtl/adc_spi_pkg.sv | 28 ++
 rtl/spi_edge_sync.sv | 41 ++++
 rtl/adc_spi_responder.sv | 276 +++++++++++++++++++++++++++
 tb/tb_adc_spi_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg
//   Shared types and constants for the ADC configuration-port SPI responder.
//   - state_t        : responder frame state
//   - FRAME_BITS     : bits per SPI frame (R/W + address + data)
//   - ADDR_BITS      : register address width
//   - DATA_BITS      : register data width
//   - RW_READ        : value of the R/W bit that selects a read
//   - addr_in_range  : true when an address hits an implemented register
package adc_spi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int FRAME_BITS = 16;
   localparam int ADDR_BITS  = 7;
   localparam int DATA_BITS  = 8;

   localparam logic RW_READ = 1'b1;

   function automatic logic addr_in_range(input logic [ADDR_BITS-1:0] addr, input int depth);
      return {25'd0, addr} < 32'(depth);
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync
//   Two-flop synchronizer for an asynchronous SPI pin followed by a
//   registered edge detector. A pin edge shows up on rise/fall three
//   clk cycles later, as a single-cycle pulse.
//   Ports:
//     clk  in  system clock
//     rst  in  synchronous active-high reset
//     din  in  asynchronous pin
//     rise out one-cycle pulse on a synchronized 0->1 transition
//     fall out one-cycle pulse on a synchronized 1->0 transition
//   All flops reset to 0, so a pin that is already low when reset
//   releases does not produce a falling edge.
module spi_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync;
   logic sync_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta   <= 1'b0;
         sync   <= 1'b0;
         sync_d <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         meta   <= din;
         sync   <= meta;
         sync_d <= sync;
         rise   <= sync & ~sync_d;
         fall   <= ~sync & sync_d;
      end
   end

endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder
//   SPI responder for the configuration port of the quad-channel fast ADC.
//   Decodes 16-bit frames {R/W, addr[6:0], data[7:0]} (MSB first) from an
//   oversampled SPI initiator and holds DEPTH 8-bit registers.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a synchronized CSN falling edge
//   CMD   | shifting R/W + address (first 8 SCLK rises)
//   DATA  | shifting write data / driving read data (rises 9..16)
//   DONE  | frame complete, edges ignored until CSN rises
//
//   Ports:
//     CLK, RST         clock and synchronous active-high reset
//     ADC_CSN/SCLK/SDI asynchronous SPI inputs
//     ADC_SD0, SDO_OE  read data out and its drive enable
//     WR_STROBE        one-cycle pulse on a write to an implemented register
//     WR_ADDR, WR_DATA address and data of the last accepted write
//     REG_FLAT         register n on bits [8n+7:8n]
//     ERR_ABORT        one-cycle pulse when CSN rises mid-frame
//     FRAME_CNT        completed frame count, wraps
module adc_spi_responder
   import adc_spi_pkg::*;
#(
   parameter int                DEPTH        = 16,
   parameter logic [DEPTH*8-1:0] RESET_VALUES = {DEPTH*8{1'b0}}
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 ADC_CSN,
   input  logic                 ADC_SCLK,
   input  logic                 ADC_SDI,
   output logic                 ADC_SD0,
   output logic                 SDO_OE,
   output logic                 WR_STROBE,
   output logic [6:0]           WR_ADDR,
   output logic [7:0]           WR_DATA,
   output logic [DEPTH*8-1:0]   REG_FLAT,
   output logic                 ERR_ABORT,
   output logic [15:0]          FRAME_CNT
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(FRAME_BITS);

   // Bit counter runs down from FRAME_BITS-1; the command byte is complete
   // when the rise that sees DATA_BITS arrives, the frame when it sees 0.
   localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_CMD_TC = CNT_W'(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_END_TC = '0;

   logic sclk_rise;
   logic sclk_fall;
   logic csn_rise;
   logic csn_fall;
   logic sdi_meta;
   logic sdi_sync;

   state_t state;
   state_t state_nxt;

   logic [CNT_W-1:0]        bit_cnt;
   logic [FRAME_BITS-2:0]   shift_reg;
   logic [FRAME_BITS-1:0]   shift_nxt;
   logic                    is_read;
   logic [DATA_BITS-1:0]    rd_shift;
   logic [DATA_BITS-1:0]    rd_word;
   logic [DATA_BITS-1:0]    regs [DEPTH];

   logic                    do_load;
   logic                    do_shift;
   logic                    do_cmd_done;
   logic                    do_frame_done;
   logic                    do_abort;
   logic                    do_count;
   logic                    wr_hit;

   logic [ADDR_BITS-1:0]    cmd_addr;
   logic                    cmd_rw;
   logic [ADDR_BITS-1:0]    frm_addr;
   logic [DATA_BITS-1:0]    frm_data;
   logic                    frm_rw;

   logic                    sd0_q;
   logic                    oe_q;
   logic                    wr_strobe_q;
   logic [ADDR_BITS-1:0]    wr_addr_q;
   logic [DATA_BITS-1:0]    wr_data_q;
   logic                    err_q;
   logic [15:0]             frame_cnt;

   spi_edge_sync u_sclk_sync (
      .clk  (CLK),
      .rst  (RST),
      .din  (ADC_SCLK),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   spi_edge_sync u_csn_sync (
      .clk  (CLK),
      .rst  (RST),
      .din  (ADC_CSN),
      .rise (csn_rise),
      .fall (csn_fall)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         sdi_meta <= 1'b0;
         sdi_sync <= 1'b0;
      end else begin
         sdi_meta <= ADC_SDI;
         sdi_sync <= sdi_meta;
      end
   end

   // Shift register as it will look after the current rise; the decode
   // below is only used in the cycle that rise is being consumed.
   assign shift_nxt = {shift_reg, sdi_sync};
   assign cmd_addr  = shift_nxt[ADDR_BITS-1:0];
   assign cmd_rw    = shift_nxt[DATA_BITS-1];
   assign frm_rw    = shift_nxt[FRAME_BITS-1];
   assign frm_addr  = shift_nxt[FRAME_BITS-2 -: ADDR_BITS];
   assign frm_data  = shift_nxt[DATA_BITS-1:0];

   always_comb begin
      rd_word = '0;
      if (addr_in_range(cmd_addr, DEPTH)) begin
         rd_word = regs[cmd_addr[IDX_W-1:0]];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      do_load       = 1'b0;
      do_shift      = 1'b0;
      do_cmd_done   = 1'b0;
      do_frame_done = 1'b0;
      do_abort      = 1'b0;
      do_count      = 1'b0;
      case (state)
         IDLE: begin
            if (csn_fall) begin
               state_nxt = CMD;
               do_load   = 1'b1;
            end
         end
         CMD: begin
            if (csn_rise) begin
               state_nxt = IDLE;
               do_abort  = 1'b1;
            end else if (sclk_rise) begin
               do_shift = 1'b1;
               if (bit_cnt == CNT_CMD_TC) begin
                  state_nxt   = DATA;
                  do_cmd_done = 1'b1;
               end
            end
         end
         DATA: begin
            if (csn_rise) begin
               state_nxt = IDLE;
               do_abort  = 1'b1;
            end else if (sclk_rise) begin
               do_shift = 1'b1;
               if (bit_cnt == CNT_END_TC) begin
                  state_nxt     = DONE;
                  do_frame_done = 1'b1;
               end
            end
         end
         DONE: begin
            if (csn_rise) begin
               state_nxt = IDLE;
               do_count  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign wr_hit = do_frame_done && (frm_rw != RW_READ) && addr_in_range(frm_addr, DEPTH);

   always_ff @(posedge CLK) begin
      if (RST) begin
         bit_cnt     <= '0;
         shift_reg   <= '0;
         is_read     <= 1'b0;
         rd_shift    <= '0;
         sd0_q       <= 1'b0;
         oe_q        <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         err_q       <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         wr_strobe_q <= 1'b0;
         err_q       <= 1'b0;

         if (do_load) begin
            bit_cnt <= CNT_LOAD;
            is_read <= 1'b0;
         end

         if (do_shift) begin
            shift_reg <= shift_nxt[FRAME_BITS-2:0];
            bit_cnt   <= bit_cnt - 1'b1;
         end

         // The read word is captured once, at the end of the command byte,
         // so a later write in the same frame cannot disturb it.
         if (do_cmd_done) begin
            is_read  <= (cmd_rw == RW_READ);
            rd_shift <= rd_word;
         end

         if (wr_hit) begin
            wr_strobe_q <= 1'b1;
            wr_addr_q   <= frm_addr;
            wr_data_q   <= frm_data;
         end

         if ((state == DATA) && is_read && sclk_fall) begin
            sd0_q    <= rd_shift[DATA_BITS-1];
            rd_shift <= {rd_shift[DATA_BITS-2:0], 1'b0};
            oe_q     <= 1'b1;
         end

         if (csn_rise) begin
            sd0_q <= 1'b0;
            oe_q  <= 1'b0;
         end

         if (do_abort) begin
            err_q <= 1'b1;
         end

         if (do_count) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= RESET_VALUES[8*i +: 8];
         end
      end else if (wr_hit) begin
         regs[frm_addr[IDX_W-1:0]] <= frm_data;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign REG_FLAT[8*g +: 8] = regs[g];
   end

   assign ADC_SD0   = sd0_q & oe_q;
   assign SDO_OE    = oe_q;
   assign WR_STROBE = wr_strobe_q;
   assign WR_ADDR   = wr_addr_q;
   assign WR_DATA   = wr_data_q;
   assign ERR_ABORT = err_q;
   assign FRAME_CNT = frame_cnt;

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder
//   Table of write/read frames with hand-computed expectations, plus
//   sequences for abort, mid-frame reset and frame-counter wrap. Expected
//   writes and read words are queued when a frame is driven and popped
//   when the DUT strobes or the read word has been shifted out.
module tb_adc_spi_responder;

   localparam int DEPTH = 16;
   // reg3 = 0x3C, reg9 = 0xA5, all others 0
   localparam logic [DEPTH*8-1:0] RST_VALS = 128'h0000_0000_0000_A500_0000_0000_3C00_0000;

   logic                 clk;
   logic                 RST;
   logic                 ADC_CSN;
   logic                 ADC_SCLK;
   logic                 ADC_SDI;
   logic                 ADC_SD0;
   logic                 SDO_OE;
   logic                 WR_STROBE;
   logic [6:0]           WR_ADDR;
   logic [7:0]           WR_DATA;
   logic [DEPTH*8-1:0]   REG_FLAT;
   logic                 ERR_ABORT;
   logic [15:0]          FRAME_CNT;

   adc_spi_responder #(
      .DEPTH        (DEPTH),
      .RESET_VALUES (RST_VALS)
   ) dut (
      .CLK       (clk),
      .RST       (RST),
      .ADC_CSN   (ADC_CSN),
      .ADC_SCLK  (ADC_SCLK),
      .ADC_SDI   (ADC_SDI),
      .ADC_SD0   (ADC_SD0),
      .SDO_OE    (SDO_OE),
      .WR_STROBE (WR_STROBE),
      .WR_ADDR   (WR_ADDR),
      .WR_DATA   (WR_DATA),
      .REG_FLAT  (REG_FLAT),
      .ERR_ABORT (ERR_ABORT),
      .FRAME_CNT (FRAME_CNT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rw;
      logic [6:0] addr;
      logic [7:0] data;
      int         half;
      int         exp_strobe;
      logic [7:0] exp_rd;
   } vec_t;

   vec_t vecs [14];

   int checks = 0;
   int errors = 0;
   int strobe_cnt = 0;
   int abort_cnt = 0;
   int oe_err = 0;

   logic [14:0]        wr_q [$];
   logic [7:0]         rd_q [$];
   logic [14:0]        exp_w;
   logic [7:0]         exp_r;
   logic [7:0]         rd_word;
   logic [DEPTH*8-1:0] exp_flat;
   logic [15:0]        exp_fc;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (WR_STROBE === 1'b1) begin
         strobe_cnt++;
         if (wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe actual addr %0h data %0h expected no strobe", WR_ADDR, WR_DATA);
         end else begin
            exp_w = wr_q.pop_front();
            check("wr_addr", 128'(WR_ADDR), 128'(exp_w[14:8]));
            check("wr_data", 128'(WR_DATA), 128'(exp_w[7:0]));
         end
      end
      if (ERR_ABORT === 1'b1) abort_cnt++;
   end

   // Called right after a negedge; SDI and the SCLK fall change together.
   task automatic sclk_cycle(input logic sdi_bit, input int half, input int idx, input logic rd);
      logic exp_oe;
      ADC_SDI = sdi_bit;
      repeat (half) @(negedge clk);
      ADC_SCLK = 1'b1;
      exp_oe = rd && (idx >= 8);
      if (SDO_OE !== exp_oe) oe_err++;
      if (!exp_oe && ADC_SD0 !== 1'b0) oe_err++;
      if (idx >= 8 && idx < 16) rd_word = {rd_word[6:0], ADC_SD0};
      repeat (half) @(negedge clk);
      ADC_SCLK = 1'b0;
   endtask

   task automatic run_frame(input logic [15:0] frame, input int nbits, input int half);
      rd_word = '0;
      oe_err  = 0;
      @(negedge clk);
      ADC_CSN = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         sclk_cycle((i < 16) ? frame[15-i] : 1'b1, half, i, frame[15]);
      end
      repeat (6) @(negedge clk);
      ADC_CSN = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v, input int nbits);
      int s0;
      int a0;
      s0 = strobe_cnt;
      a0 = abort_cnt;
      if (!v.rw && v.exp_strobe == 1) wr_q.push_back({v.addr, v.data});
      if (v.rw) rd_q.push_back(v.exp_rd);
      run_frame({v.rw, v.addr, v.data}, nbits, v.half);
      exp_fc = exp_fc + 16'd1;
      if (!v.rw && v.exp_strobe == 1) exp_flat[int'(v.addr)*8 +: 8] = v.data;
      if (v.rw) begin
         exp_r = rd_q.pop_front();
         check("rd_data", 128'(rd_word), 128'(exp_r));
      end
      check("strobes", 128'(strobe_cnt - s0), 128'(v.exp_strobe));
      check("aborts", 128'(abort_cnt - a0), 128'(0));
      check("oe_window", 128'(oe_err), 128'(0));
      check("frame_cnt", 128'(FRAME_CNT), 128'(exp_fc));
      check("reg_flat", REG_FLAT, exp_flat);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   s0;
      int   a0;

      RST      = 1'b1;
      ADC_CSN  = 1'b1;
      ADC_SCLK = 1'b0;
      ADC_SDI  = 1'b0;
      exp_flat = RST_VALS;
      exp_fc   = '0;
      rd_word  = '0;

      //           rw    addr   data   half strobe exp_rd
      vecs[0]  = '{1'b0, 7'h05, 8'h14, 4, 1, 8'h00};
      vecs[1]  = '{1'b1, 7'h05, 8'h00, 4, 0, 8'h14};
      vecs[2]  = '{1'b0, 7'h7F, 8'hAA, 5, 0, 8'h00};
      vecs[3]  = '{1'b1, 7'h7F, 8'h00, 5, 0, 8'h00};
      vecs[4]  = '{1'b1, 7'h03, 8'hFF, 6, 0, 8'h3C};
      vecs[5]  = '{1'b0, 7'h00, 8'h5A, 4, 1, 8'h00};
      vecs[6]  = '{1'b1, 7'h00, 8'h00, 5, 0, 8'h5A};
      vecs[7]  = '{1'b0, 7'h0F, 8'hC3, 6, 1, 8'h00};
      vecs[8]  = '{1'b1, 7'h0F, 8'h00, 4, 0, 8'hC3};
      vecs[9]  = '{1'b0, 7'h10, 8'h77, 5, 0, 8'h00};
      vecs[10] = '{1'b1, 7'h10, 8'h00, 5, 0, 8'h00};
      vecs[11] = '{1'b1, 7'h09, 8'h00, 4, 0, 8'hA5};
      vecs[12] = '{1'b0, 7'h09, 8'h01, 4, 1, 8'h00};
      vecs[13] = '{1'b1, 7'h09, 8'h00, 6, 0, 8'h01};

      repeat (5) @(negedge clk);
      check("rst_sd0", 128'(ADC_SD0), 128'(0));
      check("rst_oe", 128'(SDO_OE), 128'(0));
      check("rst_strobe", 128'(WR_STROBE), 128'(0));
      check("rst_abort", 128'(ERR_ABORT), 128'(0));
      check("rst_frame_cnt", 128'(FRAME_CNT), 128'(0));
      check("rst_wr_addr", 128'(WR_ADDR), 128'(0));
      check("rst_wr_data", 128'(WR_DATA), 128'(0));
      check("rst_reg_flat", REG_FLAT, RST_VALS);
      RST = 1'b0;
      repeat (5) @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         run_vec(vecs[i], 16);
      end

      // CSN raised after 11 SCLK cycles of a write
      s0 = strobe_cnt;
      a0 = abort_cnt;
      run_frame({1'b0, 7'h05, 8'hEE}, 11, 5);
      check("abort_pulse", 128'(abort_cnt - a0), 128'(1));
      check("abort_strobes", 128'(strobe_cnt - s0), 128'(0));
      check("abort_frame_cnt", 128'(FRAME_CNT), 128'(exp_fc));
      check("abort_reg_flat", REG_FLAT, exp_flat);
      check("abort_oe", 128'(oe_err), 128'(0));
      v = '{1'b0, 7'h05, 8'h66, 5, 1, 8'h00};
      run_vec(v, 16);
      v = '{1'b1, 7'h05, 8'h00, 5, 0, 8'h66};
      run_vec(v, 16);

      // RST in the middle of a read frame
      s0 = strobe_cnt;
      a0 = abort_cnt;
      rd_word = '0;
      oe_err  = 0;
      @(negedge clk);
      ADC_CSN = 1'b0;
      repeat (6) @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         sclk_cycle((i == 0) ? 1'b1 : ((i == 5 || i == 7) ? 1'b1 : 1'b0), 5, i, 1'b1);
      end
      check("pre_rst_oe", 128'(SDO_OE), 128'(1));
      RST = 1'b1;
      @(negedge clk);
      @(negedge clk);
      exp_flat = RST_VALS;
      exp_fc   = '0;
      check("midrst_sd0", 128'(ADC_SD0), 128'(0));
      check("midrst_oe", 128'(SDO_OE), 128'(0));
      check("midrst_reg_flat", REG_FLAT, exp_flat);
      check("midrst_frame_cnt", 128'(FRAME_CNT), 128'(exp_fc));
      RST = 1'b0;
      oe_err = 0;
      for (int i = 12; i < 16; i++) begin
         sclk_cycle(1'b0, 5, i, 1'b0);
      end
      repeat (6) @(negedge clk);
      ADC_CSN = 1'b1;
      repeat (8) @(negedge clk);
      check("midrst_aborts", 128'(abort_cnt - a0), 128'(0));
      check("midrst_strobes", 128'(strobe_cnt - s0), 128'(0));
      check("midrst_frame_cnt_after", 128'(FRAME_CNT), 128'(0));
      check("midrst_oe_after", 128'(oe_err), 128'(0));
      v = '{1'b0, 7'h02, 8'h99, 5, 1, 8'h00};
      run_vec(v, 16);
      v = '{1'b1, 7'h02, 8'h00, 5, 0, 8'h99};
      run_vec(v, 16);

      // FRAME_CNT wrap with a 20-cycle write at minimum SCLK phases
      @(negedge clk);
      force dut.frame_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.frame_cnt;
      @(negedge clk);
      exp_fc = 16'hFFFF;
      check("fc_preload", 128'(FRAME_CNT), 128'(exp_fc));
      v = '{1'b0, 7'h0A, 8'h3E, 4, 1, 8'h00};
      run_vec(v, 20);
      check("fc_wrapped", 128'(FRAME_CNT), 128'(16'h0000));

      check("wr_q_empty", 128'(wr_q.size()), 128'(0));
      check("rd_q_empty", 128'(rd_q.size()), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
